// File: rtl/div113_seq.sv
// Multi-cycle unsigned divide-by-constant (default 113): radix-16 digit recurrence,
// one quotient digit per cycle, valid/ready handshake on both sides.
module div113_seq #(
  parameter int DIVIDEND_W = 60,
  parameter int DIVISOR    = 113,
  parameter int DIGIT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] in_dividend,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] out_quotient,
  output logic [6:0]            out_remainder
);

  localparam int REM_W = 7;
  localparam int V_W   = REM_W + DIGIT_W;
  localparam int NDIG  = DIVIDEND_W / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q;
  logic [DIVIDEND_W-1:0] shift_q;
  logic [REM_W-1:0]      rem_q;
  logic [CNT_W-1:0]      count_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic [V_W-1:0]        v_d;
  logic [V_W-1:0]        prod_d;
  logic [DIGIT_W-1:0]    digit_d;
  logic [REM_W-1:0]      rem_d;

  // Digit selection by comparing against every multiple k*DIVISOR; the thresholds are monotonic,
  // so the last one passed is the digit and its multiple is what gets subtracted.
  always_comb begin
    v_d     = {rem_q, shift_q[DIVIDEND_W-1 -: DIGIT_W]};
    digit_d = '0;
    prod_d  = '0;
    for (int k = 1; k < (1 << DIGIT_W); k++) begin
      if (v_d >= V_W'(k * DIVISOR)) begin
        digit_d = DIGIT_W'(k);
        prod_d  = V_W'(k * DIVISOR);
      end
    end
    rem_d = REM_W'(v_d - prod_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      rem_q       <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            shift_q    <= in_dividend;
            rem_q      <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          // Quotient digits enter at the LSBs as dividend digits leave the top.
          shift_q <= {shift_q[DIVIDEND_W-DIGIT_W-1:0], digit_d};
          rem_q   <= rem_d;
          count_q <= count_q + CNT_W'(1);
          if (count_q == LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_quotient  = shift_q;
  assign out_remainder = rem_q;

  a_rem_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RUN) |-> (rem_q < REM_W'(DIVISOR)));

endmodule

// File: tb/tb_div113_seq.sv
// Directed and small randomized bench for div113_seq: latency, boundary values,
// back-pressure, asynchronous reset and back-to-back streaming.
module tb_div113_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [59:0] in_dividend = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [59:0] out_quotient;
  logic [6:0]  out_remainder;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div113_seq #(.DIVIDEND_W(60), .DIVISOR(113), .DIGIT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one dividend, then waits for out_valid; leaves the DUT holding its result.
  task automatic run_op(input logic [59:0] d, output logic [59:0] q, output logic [6:0] r,
                        output int lat, output bit ok);
    int w;
    w   = 0;
    ok  = 1'b1;
    lat = 0;
    q   = '0;
    r   = '0;
    while (!in_ready && w < 40) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      return;
    end
    in_valid    = 1'b1;
    in_dividend = d;
    tick();
    in_valid    = 1'b0;
    in_dividend = 60'({$urandom(), $urandom()});
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      ok = 1'b0;
      return;
    end
    q = out_quotient;
    r = out_remainder;
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
    total++; if (out_quotient !== 60'd0) begin bad++; $display("[TB] FAIL rst_quotient: got %0d expected 0", out_quotient); end
    total++; if (out_remainder !== 7'd0) begin bad++; $display("[TB] FAIL rst_remainder: got %0d expected 0", out_remainder); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL post_rst_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [59:0] dv [8];
    logic [59:0] qv [8];
    logic [6:0]  rv [8];
    logic [59:0] q;
    logic [6:0]  r;
    int          lat;
    bit          ok;
    dv = '{60'd0, 60'd112, 60'd113, 60'd12768, 60'd12769, 60'd1000000, 60'd113000000, 60'hFFFFFFFFFFFFFFF};
    qv = '{60'd0, 60'd0,   60'd1,   60'd112,   60'd113,   60'd8849,    60'd1000000,   60'd10202845173511920};
    rv = '{7'd0,  7'd112,  7'd0,    7'd112,    7'd0,      7'd63,       7'd0,          7'd15};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_op(dv[i], q, r, lat, ok);
      total++;
      if (!ok) begin
        bad++; $display("[TB] FAIL dir_timeout[%0d]: no result for dividend %0d", i, dv[i]);
      end else begin
        if (lat !== 15) begin bad++; $display("[TB] FAIL dir_latency[%0d]: got %0d expected 15", i, lat); end
        total++; if (q !== qv[i]) begin bad++; $display("[TB] FAIL dir_quotient[%0d]: got %0d expected %0d", i, q, qv[i]); end
        total++; if (r !== rv[i]) begin bad++; $display("[TB] FAIL dir_remainder[%0d]: got %0d expected %0d", i, r, rv[i]); end
        total++; if (q[59:54] !== 6'd0) begin bad++; $display("[TB] FAIL dir_q_top[%0d]: got %0d expected 0", i, q[59:54]); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [59:0] q;
    logic [6:0]  r;
    int          lat;
    bit          ok;
    out_ready = 1'b0;
    run_op(60'd12768, q, r, lat, ok);
    total++;
    if (!ok) begin
      bad++; $display("[TB] FAIL bp_timeout: no result");
    end else if (q !== 60'd112 || r !== 7'd112) begin
      bad++; $display("[TB] FAIL bp_result: got q=%0d r=%0d expected q=112 r=112", q, r);
    end
    for (int c = 0; c < 20; c++) begin
      in_valid    = 1'b1;
      in_dividend = 60'd5;
      tick();
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quotient !== 60'd112 || out_remainder !== 7'd112) begin
        bad++;
        $display("[TB] FAIL bp_hold[%0d]: got v=%b rdy=%b q=%0d r=%0d expected 1/0/112/112",
                 c, out_valid, in_ready, out_quotient, out_remainder);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    tick();
    total++; if (in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL bp_ignored_valid: got in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [59:0] q;
    logic [6:0]  r;
    int          lat;
    bit          ok;
    out_ready   = 1'b1;
    in_valid    = 1'b1;
    in_dividend = 60'hFFFFFFFFFFFFFFF;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 7; c++) tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_run_busy: got in_ready=%b expected 0", in_ready); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_run_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    total++; if (out_quotient !== 60'd0 || out_remainder !== 7'd0) begin
      bad++; $display("[TB] FAIL mid_run_clear: got q=%0d r=%0d expected 0/0", out_quotient, out_remainder);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(60'd12769, q, r, lat, ok);
    total++;
    if (!ok) begin
      bad++; $display("[TB] FAIL after_rst_timeout: no result");
    end else if (lat !== 15 || q !== 60'd113 || r !== 7'd0) begin
      bad++; $display("[TB] FAIL after_rst_result: got lat=%0d q=%0d r=%0d expected 15/113/0", lat, q, r);
    end
    tick();
    out_ready = 1'b0;
    run_op(60'd113, q, r, lat, ok);
    total++; if (!ok || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_done_setup: got out_valid=%b expected 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL mid_done_reset: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [59:0] dv [3];
    logic [59:0] qv [3];
    logic [6:0]  rv [3];
    int acc, got, last;
    dv = '{60'd12769, 60'd1000000, 60'd0};
    qv = '{60'd113,   60'd8849,    60'd0};
    rv = '{7'd0,      7'd63,       7'd0};
    acc  = 0;
    got  = 0;
    last = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 3; cyc++) begin
      if (out_valid) begin
        total++;
        if (out_quotient !== qv[got] || out_remainder !== rv[got]) begin
          bad++;
          $display("[TB] FAIL b2b_result[%0d]: got q=%0d r=%0d expected q=%0d r=%0d",
                   got, out_quotient, out_remainder, qv[got], rv[got]);
        end
        if (got > 0) begin
          total++;
          if (cyc - last !== 17) begin bad++; $display("[TB] FAIL b2b_period[%0d]: got %0d expected 17", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      if (in_ready) begin
        if (acc < 3) begin
          in_dividend = dv[acc];
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    total++; if (got !== 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d results expected 3", got); end
    tick();
  endtask

  task automatic test_random();
    logic [59:0] d, q;
    logic [6:0]  r;
    logic [66:0] recon;
    int          lat, stall;
    bit          ok;
    for (int i = 0; i < 300; i++) begin
      d = 60'({$urandom(), $urandom()});
      if (i % 3 == 0) d = d >> $urandom_range(0, 59);
      out_ready = 1'b0;
      run_op(d, q, r, lat, ok);
      total++;
      if (!ok) begin
        bad++; $display("[TB] FAIL rnd_timeout[%0d]: no result", i);
      end else begin
        recon = 67'(q) * 67'd113 + 67'(r);
        if (recon !== 67'(d) || r >= 7'd113 || lat !== 15) begin
          bad++; $display("[TB] FAIL rnd_result[%0d]: d=%0d got q=%0d r=%0d lat=%0d expected q*113+r=d, r<113, lat 15",
                          i, d, q, r, lat);
        end
        stall = $urandom_range(0, 4);
        for (int s = 0; s < stall; s++) begin
          tick();
          total++;
          if (out_valid !== 1'b1 || out_quotient !== q || out_remainder !== r) begin
            bad++; $display("[TB] FAIL rnd_stall[%0d]: got v=%b q=%0d r=%0d expected 1/%0d/%0d",
                            i, out_valid, out_quotient, out_remainder, q, r);
          end
        end
      end
      out_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
